btb_and_pc: RTL and testbench

- Fetch-stage program counter register with a small direct-mapped branch target buffer (BTB) and 2-bit saturating-counter direction predictor.
- Sits inside the fetch unit. It drives the current fetch PC to instruction memory and the IF/ID register, and picks the next PC from these sources: sequential PC+4, predicted BTB target, or an execute-stage redirect on misprediction.

---
 rtl/btb_and_pc.sv | 108 ++++++++++
 tb/tb_btb_and_pc.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/btb_and_pc.sv
// Fetch-stage PC register with a direct-mapped branch target buffer and
// per-entry 2-bit saturating direction counters.
module btb_and_pc #(
  parameter int          ENTRIES  = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_enable,
  input  logic        takeBranch,
  input  logic [31:0] PC_plus_4,
  input  logic [31:0] instruction_IFID_in,
  input  logic [31:0] branch_PC,
  input  logic        incorrect_b_prediction,
  input  logic [31:0] PC_IFID_IDEX,
  input  logic [31:0] PC_plus4_IFID_out,
  output logic [31:0] PC_IFID_in
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDXW;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [ENTRIES-1:0] valid_reg;
  logic [1:0]         ctr_reg    [ENTRIES];
  logic [TAGW-1:0]    tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];

  logic [IDXW-1:0] fetch_idx;
  logic [TAGW-1:0] fetch_tag;
  logic            fetch_hit;
  logic            is_cti;
  logic            predict_taken;

  logic [IDXW-1:0] upd_idx;
  logic [TAGW-1:0] upd_tag;
  logic            upd_hit;
  logic [1:0]      upd_ctr;

  logic [31:0] pc_next;

  // Bits the predictor never looks at: only the opcode field and the
  // word-aligned part of the resolved branch PC matter here.
  logic unused_bits;
  assign unused_bits = ^{instruction_IFID_in[31:7], PC_IFID_IDEX[1:0]};

  // Fetch-side lookup always sees the contents as of the start of the cycle.
  assign fetch_idx     = PC_IFID_in[IDXW+1:2];
  assign fetch_tag     = PC_IFID_in[31:IDXW+2];
  assign fetch_hit     = valid_reg[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
  assign is_cti        = (instruction_IFID_in[6:0] == OP_BRANCH) ||
                         (instruction_IFID_in[6:0] == OP_JAL);
  assign predict_taken = fetch_hit && ctr_reg[fetch_idx][1] && is_cti;

  assign upd_idx = PC_IFID_IDEX[IDXW+1:2];
  assign upd_tag = PC_IFID_IDEX[31:IDXW+2];
  assign upd_hit = valid_reg[upd_idx] && (tag_mem[upd_idx] == upd_tag);
  assign upd_ctr = ctr_reg[upd_idx];

  // A redirect from EX outranks a stall: the wrong-path fetch must be dropped.
  always_comb begin
    pc_next = PC_plus_4;
    if (incorrect_b_prediction) begin
      pc_next = takeBranch ? branch_PC : PC_plus4_IFID_out;
    end else if (!PC_enable) begin
      pc_next = PC_IFID_in;
    end else if (predict_taken) begin
      pc_next = target_mem[fetch_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC_IFID_in <= RESET_PC;
    end else begin
      PC_IFID_in <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_reg[i] <= 2'b01;
      end
    end else if (takeBranch) begin
      valid_reg[upd_idx] <= 1'b1;
      if (upd_hit) begin
        ctr_reg[upd_idx] <= (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'b01;
      end else begin
        ctr_reg[upd_idx] <= 2'b10;
      end
    end else if (incorrect_b_prediction && upd_hit) begin
      ctr_reg[upd_idx] <= (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'b01;
    end
  end

  // Tag and target storage carries no reset; entries are qualified by valid_reg.
  always_ff @(posedge clk) begin
    if (rst_n && takeBranch) begin
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= branch_PC;
    end
  end

endmodule

// File: tb/tb_btb_and_pc.sv
// Randomised and directed scoreboard bench for btb_and_pc against a
// behavioural predictor model.
module tb_btb_and_pc;
  localparam int          ENTRIES  = 16;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] BR       = 32'h0000_0063;
  localparam logic [31:0] JAL      = 32'h0000_006F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PC_enable, takeBranch, incorrect_b_prediction;
  logic [31:0] PC_plus_4, instruction_IFID_in, branch_PC, PC_IFID_IDEX, PC_plus4_IFID_out;
  logic [31:0] PC_IFID_in;

  btb_and_pc #(.ENTRIES(ENTRIES), .RESET_PC(RESET_PC)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .PC_enable              (PC_enable),
    .takeBranch             (takeBranch),
    .PC_plus_4              (PC_plus_4),
    .instruction_IFID_in    (instruction_IFID_in),
    .branch_PC              (branch_PC),
    .incorrect_b_prediction (incorrect_b_prediction),
    .PC_IFID_IDEX           (PC_IFID_IDEX),
    .PC_plus4_IFID_out      (PC_plus4_IFID_out),
    .PC_IFID_in             (PC_IFID_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: one record per BTB slot, keyed by word address modulo ENTRIES.
  bit          m_valid  [ENTRIES];
  logic [31:0] m_upper  [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic [31:0] m_pc;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: PC_IFID_in=%h expected %h", name, act, exp);
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_pc = RESET_PC;
  endtask

  task automatic set_idle();
    PC_enable = 1'b0; takeBranch = 1'b0; incorrect_b_prediction = 1'b0;
    PC_plus_4 = '0; instruction_IFID_in = NOP; branch_PC = '0;
    PC_IFID_IDEX = '0; PC_plus4_IFID_out = '0;
  endtask

  task automatic step(input bit en, input bit tb, input bit inc, input logic [31:0] bpc,
                      input logic [31:0] idex, input logic [31:0] p4out,
                      input logic [31:0] instr, input string name);
    int          fi, ui;
    logic [6:0]  op;
    bit          pred, uhit;
    logic [31:0] nxt;
    @(negedge clk);
    PC_enable = en; takeBranch = tb; incorrect_b_prediction = inc;
    branch_PC = bpc; PC_IFID_IDEX = idex; PC_plus4_IFID_out = p4out;
    instruction_IFID_in = instr; PC_plus_4 = m_pc + 32'd4;

    fi   = int'((m_pc / 4) % ENTRIES);
    op   = instr[6:0];
    pred = m_valid[fi] && (m_upper[fi] == m_pc / (4 * ENTRIES)) && (m_ctr[fi] >= 2)
           && (op == 7'h63 || op == 7'h6F);
    if (inc)       nxt = tb ? bpc : p4out;
    else if (!en)  nxt = m_pc;
    else if (pred) nxt = m_target[fi];
    else           nxt = m_pc + 32'd4;
    sb.push_back('{exp: nxt, name: name});

    ui   = int'((idex / 4) % ENTRIES);
    uhit = m_valid[ui] && (m_upper[ui] == idex / (4 * ENTRIES));
    if (tb) begin
      m_target[ui] = bpc;
      if (uhit) begin
        m_ctr[ui] = (m_ctr[ui] + 1 > 3) ? 3 : m_ctr[ui] + 1;
      end else begin
        m_valid[ui] = 1'b1;
        m_upper[ui] = idex / (4 * ENTRIES);
        m_ctr[ui]   = 2;
      end
    end else if (inc && uhit) begin
      m_ctr[ui] = (m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1;
    end
    m_pc = nxt;
  endtask

  // Redirect the fetch PC via a not-taken recovery on a slot never used in the directed phase.
  task automatic go(input logic [31:0] addr);
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FF3C, addr, NOP, "redirect");
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] hi;
    hi = ($urandom_range(0, 7) == 0) ? 32'h8000_1000 : 32'h0;
    return hi | (32'($urandom_range(0, 63)) << 2);
  endfunction

  function automatic logic [31:0] rand_instr();
    case ($urandom_range(0, 3))
      0: return BR;
      1: return JAL;
      2: return NOP;
      default: return $urandom;
    endcase
  endfunction

  task automatic random_steps(input int n);
    logic [31:0] idex;
    for (int k = 0; k < n; k++) begin
      idex = rand_pc();
      step($urandom_range(0, 99) < 80, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
           rand_pc(), idex, idex + 32'd4, rand_instr(), "random");
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pending expectations, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic mid_reset();
    drain();
    #1;
    set_idle();
    rst_n = 1'b0;
    #1;
    check("async_reset", PC_IFID_in, RESET_PC);
    model_reset();
    @(negedge clk);
    check("reset_hold", PC_IFID_in, RESET_PC);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, PC_IFID_in, e.exp);
      end
    end
  end

  initial begin : stimulus
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_pc", PC_IFID_in, RESET_PC);
    rst_n = 1'b1;

    step(1, 0, 0, 0, 0, 0, NOP, "seq_4");
    step(1, 0, 0, 0, 0, 0, NOP, "seq_8");
    repeat (3) step(0, 0, 0, 0, 0, 0, NOP, "stall_hold");
    step(1, 0, 0, 0, 0, 0, NOP, "resume_12");

    step(0, 1, 1, 32'h100, 32'h10, 32'h14, NOP, "mispredict_taken");
    go(32'h10);
    step(1, 0, 0, 0, 0, 0, BR, "btb_hit_branch");
    go(32'h10);
    step(1, 0, 0, 0, 0, 0, NOP, "btb_hit_nonbranch");
    step(1, 0, 1, 0, 32'h10, 32'h14, NOP, "not_taken_recovery");
    go(32'h10);
    step(1, 0, 0, 0, 0, 0, BR, "decayed_not_taken");

    step(1, 1, 0, 32'h300, 32'h50, 32'h54, NOP, "alias_update");
    go(32'h10);
    step(1, 0, 0, 0, 0, 0, BR, "alias_miss");
    go(32'h50);
    step(1, 0, 0, 0, 0, 0, BR, "alias_hit");
    repeat (4) step(1, 1, 0, 32'h300, 32'h50, 32'h54, NOP, "sat_update");
    step(1, 0, 1, 0, 32'h50, 32'h54, NOP, "sat_decrement");
    go(32'h50);
    step(1, 0, 0, 0, 0, 0, BR, "sat_still_taken");
    go(32'h50);
    step(1, 0, 0, 0, 0, 0, JAL, "jal_predicted");

    step(0, 1, 1, 32'hFFFF_FFFC, 32'h80, 32'h84, NOP, "redirect_top");
    step(1, 0, 0, 0, 0, 0, NOP, "pc_wrap");

    random_steps(400);
    mid_reset();
    step(1, 0, 0, 0, 0, 0, NOP, "post_reset_seq");
    random_steps(300);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
